// File: rtl/motion_pkg.sv
// Shared types and pixel layout constants for the motion pipeline stages.
package motion_pkg;

  // Writer FSM states; the encoding leaves room so a corrupted state is decodable.
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WRITE = 2'd1
  } state_t;

  localparam int unsigned PIXEL_WIDTH = 24;

  // Channel slices of a packed RGB pixel: {R, G, B}.
  localparam int unsigned R_HI = 23;
  localparam int unsigned R_LO = 16;
  localparam int unsigned G_HI = 15;
  localparam int unsigned G_LO = 8;
  localparam int unsigned B_HI = 7;
  localparam int unsigned B_LO = 0;

endpackage

// File: rtl/rgb_to_gray.sv
// Combinational RGB to grayscale: floor((R + G + B) / 3), exact for every input.
module rgb_to_gray #(
  parameter int unsigned CHANNEL_WIDTH = 8
) (
  input  logic [3*CHANNEL_WIDTH-1:0] rgb_i,
  output logic [CHANNEL_WIDTH-1:0]   gray_o
);

  // Two extra bits hold the sum of three full-scale channels without overflow.
  localparam int unsigned SumW = CHANNEL_WIDTH + 2;

  logic [SumW-1:0] sum;

  // Sum the channels, then divide; the quotient always fits in one channel.
  always_comb begin
    sum    = SumW'(rgb_i[3*CHANNEL_WIDTH-1:2*CHANNEL_WIDTH])
           + SumW'(rgb_i[2*CHANNEL_WIDTH-1:CHANNEL_WIDTH])
           + SumW'(rgb_i[CHANNEL_WIDTH-1:0]);
    gray_o = CHANNEL_WIDTH'(sum / SumW'(3));
  end

endmodule

// File: rtl/grayscale_fork.sv
// Pops RGB pixels, converts to gray and writes each gray word exactly once to two
// independently back-pressured FIFOs, sustaining one pixel per clock when unblocked.
module grayscale_fork
  import motion_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       in_rd_en,
  input  logic                       in_empty,
  input  logic [3*CHANNEL_WIDTH-1:0] in_dout,
  output logic                       a_wr_en,
  input  logic                       a_full,
  output logic [3*CHANNEL_WIDTH-1:0] a_din,
  output logic                       b_wr_en,
  input  logic                       b_full,
  output logic [3*CHANNEL_WIDTH-1:0] b_din
);

  state_t                   state_q, state_d;
  logic [CHANNEL_WIDTH-1:0] gray_q, gray_d;
  logic                     pend_a_q, pend_a_d;
  logic                     pend_b_q, pend_b_d;
  logic [CHANNEL_WIDTH-1:0] gray_new;
  logic                     done;

  rgb_to_gray #(
    .CHANNEL_WIDTH(CHANNEL_WIDTH)
  ) u_rgb_to_gray (
    .rgb_i (in_dout),
    .gray_o(gray_new)
  );

  // State, held gray value and per-destination pending flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_LOAD;
      gray_q   <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gray_q   <= gray_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end

  // Next-state and strobes; a pop happens only when the current pixel is fully delivered.
  always_comb begin
    state_d  = state_q;
    gray_d   = gray_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    in_rd_en = 1'b0;
    a_wr_en  = 1'b0;
    b_wr_en  = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (!in_empty) begin
          in_rd_en = 1'b1;
          gray_d   = gray_new;
          pend_a_d = 1'b1;
          pend_b_d = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        a_wr_en  = pend_a_q & ~a_full;
        b_wr_en  = pend_b_q & ~b_full;
        pend_a_d = pend_a_q & ~a_wr_en;
        pend_b_d = pend_b_q & ~b_wr_en;
        done     = (~pend_a_q | a_wr_en) & (~pend_b_q | b_wr_en);
        if (done) begin
          if (!in_empty) begin
            in_rd_en = 1'b1;
            gray_d   = gray_new;
            pend_a_d = 1'b1;
            pend_b_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        state_d  = S_LOAD;
        pend_a_d = 1'b0;
        pend_b_d = 1'b0;
      end
    endcase

    // A reset cycle must not let a held pixel leak out or consume an input word.
    if (reset) begin
      in_rd_en = 1'b0;
      a_wr_en  = 1'b0;
      b_wr_en  = 1'b0;
    end
  end

  // Data buses are zero unless their write strobe is active.
  always_comb begin
    a_din = a_wr_en ? {3{gray_q}} : '0;
    b_din = b_wr_en ? {3{gray_q}} : '0;
  end

endmodule

// File: tb/tb_grayscale_fork.sv
// Randomized and directed bench for grayscale_fork with a queue-based reference model.
module tb_grayscale_fork;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_rd_en;
  logic        in_empty = 1'b1;
  logic [23:0] in_dout = '0;
  logic        a_wr_en;
  logic        a_full = 1'b0;
  logic [23:0] a_din;
  logic        b_wr_en;
  logic        b_full = 1'b0;
  logic [23:0] b_din;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] src_q[$];
  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];

  // Last sampled strobes and counters, used by directed checks.
  logic        last_rd, last_a, last_b;
  logic [23:0] last_a_din, last_b_din;
  int          n_pops, n_a_wr, n_b_wr;

  grayscale_fork #(
    .CHANNEL_WIDTH(8)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in_rd_en(in_rd_en),
    .in_empty(in_empty),
    .in_dout (in_dout),
    .a_wr_en (a_wr_en),
    .a_full  (a_full),
    .a_din   (a_din),
    .b_wr_en (b_wr_en),
    .b_full  (b_full),
    .b_din   (b_din)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Gray word straight from the arithmetic rule: floor((R+G+B)/3) on every channel.
  function automatic logic [23:0] word_ref(input logic [23:0] p);
    int s;
    int g;
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    g = s / 3;
    return {3{8'(g)}};
  endfunction

  // One clock: drive inputs after the falling edge, sample and score before the rising edge.
  task automatic cycle(input logic af, input logic bf, input logic hold_empty);
    logic [23:0] e;
    @(negedge clock);
    a_full   = af;
    b_full   = bf;
    in_empty = hold_empty || (src_q.size() == 0);
    in_dout  = in_empty ? 24'($urandom) : src_q[0];
    #1;
    last_rd    = in_rd_en;
    last_a     = a_wr_en;
    last_b     = b_wr_en;
    last_a_din = a_din;
    last_b_din = b_din;
    if (reset) begin
      check_eq("reset_strobes", 32'({in_rd_en, a_wr_en, b_wr_en}), 32'd0);
      exp_a.delete();
      exp_b.delete();
    end else begin
      check_eq("rd_while_empty", 32'(in_rd_en & in_empty), 32'd0);
      check_eq("a_wr_while_full", 32'(a_wr_en & a_full), 32'd0);
      check_eq("b_wr_while_full", 32'(b_wr_en & b_full), 32'd0);
      if (a_wr_en) begin
        n_a_wr++;
        if (exp_a.size() == 0) check_eq("a_unexpected_write", 32'd1, 32'd0);
        else begin
          e = exp_a.pop_front();
          check_eq("a_din", 32'(a_din), 32'(e));
        end
      end else check_eq("a_din_idle", 32'(a_din), 32'd0);
      if (b_wr_en) begin
        n_b_wr++;
        if (exp_b.size() == 0) check_eq("b_unexpected_write", 32'd1, 32'd0);
        else begin
          e = exp_b.pop_front();
          check_eq("b_din", 32'(b_din), 32'(e));
        end
      end else check_eq("b_din_idle", 32'(b_din), 32'd0);
      // A pixel popped now can only be written from the next cycle on.
      if (in_rd_en && !in_empty) begin
        n_pops++;
        e = src_q.pop_front();
        exp_a.push_back(word_ref(e));
        exp_b.push_back(word_ref(e));
      end
    end
  endtask

  task automatic run(input int n, input logic af, input logic bf, input logic he);
    for (int i = 0; i < n; i++) cycle(af, bf, he);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
  endtask

  logic [23:0] ext_pix[4] = '{24'hFFFFFF, 24'h000000, 24'h010100, 24'h020100};
  logic [23:0] ext_exp[4] = '{24'hFFFFFF, 24'h000000, 24'h000000, 24'h010101};

  initial begin
    int streak;
    int budget;

    do_reset(2);

    // Reset state: idle with an empty input.
    cycle(1'b0, 1'b0, 1'b1);
    check_eq("rst_rd", 32'(last_rd), 32'd0);
    check_eq("rst_wr", 32'({last_a, last_b}), 32'd0);

    // Single pixel: pop, write both one cycle later, then back to idle.
    src_q.push_back(24'h102030);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("single_pop", 32'(last_rd), 32'd1);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("single_wr", 32'({last_a, last_b}), 32'b11);
    check_eq("single_a_din", 32'(last_a_din), 32'h202020);
    check_eq("single_b_din", 32'(last_b_din), 32'h202020);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("single_idle", 32'({last_rd, last_a, last_b}), 32'd0);

    // Extreme values against fixed expected words.
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(ext_pix[i]);
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      check_eq("extreme_a", 32'(last_a_din), 32'(ext_exp[i]));
      check_eq("extreme_b", 32'(last_b_din), 32'(ext_exp[i]));
    end

    // Split backpressure: a blocked three cycles, b must be written once only.
    src_q.push_back(24'h405060);
    src_q.push_back(24'h0A0B0C);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("split_pop", 32'(last_rd), 32'd1);
    cycle(1'b1, 1'b0, 1'b0);
    check_eq("split_c1", 32'({last_rd, last_a, last_b}), 32'b001);
    run(2, 1'b1, 1'b0, 1'b0);
    check_eq("split_c3", 32'({last_rd, last_a, last_b}), 32'b000);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("split_c4", 32'({last_rd, last_a, last_b}), 32'b110);
    check_eq("split_a_din", 32'(last_a_din), 32'h505050);
    run(2, 1'b0, 1'b0, 1'b0);

    // Streaming: eight queued pixels pop on consecutive cycles.
    n_a_wr = 0;
    n_b_wr = 0;
    streak = 0;
    for (int i = 0; i < 8; i++) src_q.push_back(24'($urandom));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (last_rd) streak++;
    end
    check_eq("stream_pops", 32'(streak), 32'd8);
    run(2, 1'b0, 1'b0, 1'b0);
    check_eq("stream_a_cnt", 32'(n_a_wr), 32'd8);
    check_eq("stream_b_cnt", 32'(n_b_wr), 32'd8);

    // Reset while both destinations hold a pixel: it must vanish.
    src_q.push_back(24'h123456);
    cycle(1'b0, 1'b0, 1'b0);
    run(3, 1'b1, 1'b1, 1'b1);
    check_eq("hold_no_wr", 32'({last_rd, last_a, last_b}), 32'd0);
    reset = 1'b1;
    cycle(1'b1, 1'b1, 1'b1);
    reset = 1'b0;
    run(2, 1'b0, 1'b0, 1'b1);
    check_eq("post_rst_quiet", 32'({last_a, last_b}), 32'd0);
    src_q.push_back(24'h303030);
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    check_eq("post_rst_a", 32'(last_a_din), 32'h303030);
    check_eq("post_rst_b", 32'(last_b_din), 32'h303030);

    // Random traffic against the queue model.
    n_pops = 0;
    n_a_wr = 0;
    n_b_wr = 0;
    for (int i = 0; i < 1000; i++) src_q.push_back(24'($urandom));
    budget = 20000;
    while ((src_q.size() != 0 || exp_a.size() != 0 || exp_b.size() != 0) && budget > 0) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0));
      budget--;
    end
    check_eq("random_timeout", 32'(budget == 0), 32'd0);
    run(3, 1'b0, 1'b0, 1'b1);
    check_eq("random_pops", 32'(n_pops), 32'd1000);
    check_eq("random_a_cnt", 32'(n_a_wr), 32'd1000);
    check_eq("random_b_cnt", 32'(n_b_wr), 32'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
